branch_resolve_unit: RTL and testbench

- Back end of the global-history branch predictor: builds the table index at fetch, tracks in-flight predicted branches, and resolves them at execute.
- When a branch resolves, it issues the counter-table write (index, actual outcome) and raises a misprediction flush.
- On a misprediction it repairs the speculative global history register (GHR).
- Sits between the fetch stage, the 2-bit counter table and the execute stage.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_fifo.sv | 64 ++++++
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 tb/tb_branch_resolve_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the global-history branch predictor: history width,
// branch opcode, in-flight entry layout and the table index hash.
package bp_pkg;

    localparam int GHR_W = 12;
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    typedef struct packed {
        logic [GHR_W-1:0] idx;
        logic             pred;
        logic [GHR_W-1:0] hist;
    } bp_entry_t;

    // Table index: word-aligned PC slice XOR history, masked to w bits.
    // The counter table calls this with the same w so both sides agree.
    function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                             input logic [31:0] hist,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return ((pc >> 2) ^ hist) & mask;
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// Circular FIFO holding in-flight predicted branches, with synchronous flush.
// Pushes while full and pops while empty are ignored.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(bp_entry_t),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[head];

    // Storage is not reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) begin
            mem[tail] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Predictor back end: hashes the fetch PC into a table index, queues in-flight
// predictions, resolves them in order at execute and repairs history on a miss.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int GHR_W = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       f_valid,
    input  logic [31:0]                f_pc,
    input  logic                       f_pred,
    output logic [GHR_W-1:0]           f_idx,
    output logic                       f_ready,
    input  logic                       e_valid,
    input  logic                       e_taken,
    output logic                       upd_valid,
    output logic [GHR_W-1:0]           upd_idx,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [GHR_W-1:0]           ghr,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [GHR_W-1:0] idx;
        logic             pred;
        logic [GHR_W-1:0] hist;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t     wr_entry;
    entry_t     head;
    logic [EW-1:0] head_raw;
    logic       q_full;
    logic       q_empty;
    logic       push_req;
    logic       pop_req;
    logic       miss;

    // Handshake: a fetch branch is accepted on a rising edge where f_valid and
    // f_ready are both high; f_ready depends only on registered occupancy.
    // e_valid has no ready; it is honoured only when something is in flight.
    assign f_ready  = !q_full;
    assign push_req = f_valid && f_ready;
    assign pop_req  = e_valid && !q_empty;

    assign f_idx = GHR_W'(bp_index(f_pc, 32'(ghr), GHR_W));

    assign wr_entry.idx  = f_idx;
    assign wr_entry.pred = f_pred;
    assign wr_entry.hist = ghr;

    assign head = entry_t'(head_raw);
    assign miss = pop_req && (e_taken != head.pred);

    // A miss flushes the queue, so the push of the same cycle never lands.
    bp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req && !miss),
        .wr_data (wr_entry),
        .pop     (pop_req && !miss),
        .flush   (miss),
        .rd_data (head_raw),
        .full    (q_full),
        .empty   (q_empty),
        .count   (inflight)
    );

    // Repair rewinds to the history seen when the missed branch was fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (miss) begin
            ghr <= {head.hist[GHR_W-2:0], e_taken};
        end else if (push_req) begin
            ghr <= {ghr[GHR_W-2:0], f_pred};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= pop_req;
            mispredict <= miss;
            if (pop_req) begin
                upd_idx   <= head.idx;
                upd_taken <= e_taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: state checks inline, table updates
// checked by a negedge monitor against a queue of hand-computed responses.
module tb_branch_resolve_unit;

    localparam int GHR_W = 12;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = GHR_W + 2;

    logic             clk;
    logic             rst;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic             f_pred;
    logic [GHR_W-1:0] f_idx;
    logic             f_ready;
    logic             e_valid;
    logic             e_taken;
    logic             upd_valid;
    logic [GHR_W-1:0] upd_idx;
    logic             upd_taken;
    logic             mispredict;
    logic [GHR_W-1:0] ghr;
    logic [CNT_W-1:0] inflight;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(.GHR_W(GHR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .f_valid    (f_valid),
        .f_pc       (f_pc),
        .f_pred     (f_pred),
        .f_idx      (f_idx),
        .f_ready    (f_ready),
        .e_valid    (e_valid),
        .e_taken    (e_taken),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .ghr        (ghr),
        .inflight   (inflight)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: hold inputs across one rising edge, then release strobes
    task automatic drive(input logic fv, input logic [31:0] pc, input logic pred,
                         input logic ev, input logic tk);
        f_valid = fv;
        f_pc    = pc;
        f_pred  = pred;
        e_valid = ev;
        e_taken = tk;
        @(posedge clk);
        #1;
        f_valid = 1'b0;
        e_valid = 1'b0;
    endtask

    task automatic expect_upd(input logic [GHR_W-1:0] idx, input logic tk, input logic mis);
        exp_q.push_back({idx, tk, mis});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ghr"},        32'(ghr),        32'h0);
        check({tag, "_inflight"},   32'(inflight),   32'h0);
        check({tag, "_f_ready"},    32'(f_ready),    32'h1);
        check({tag, "_upd_valid"},  32'(upd_valid),  32'h0);
        check({tag, "_upd_idx"},    32'(upd_idx),    32'h0);
        check({tag, "_upd_taken"},  32'(upd_taken),  32'h0);
        check({tag, "_mispredict"}, 32'(mispredict), 32'h0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (upd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_upd: got idx=0x%0h taken=%0b mis=%0b expected no update",
                         upd_idx, upd_taken, mispredict);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("upd_idx",    32'(upd_idx),    32'(e[W-1:2]));
                check("upd_taken",  32'(upd_taken),  32'(e[1]));
                check("mispredict", 32'(mispredict), 32'(e[0]));
            end
        end else if (mispredict) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_mispredict: got 1 expected 0 without upd_valid");
        end
    end

    initial begin
        rst = 1'b1; f_valid = 1'b0; f_pc = '0; f_pred = 1'b0; e_valid = 1'b0; e_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("rst0");

        // index hash and first push
        f_pc = 32'h40; f_pred = 1'b1;
        #1;
        check("f_idx_first", 32'(f_idx), 32'h010);
        drive(1, 32'h40, 1, 0, 0);
        check("ghr_first", 32'(ghr), 32'h001);
        check("inflight_first", 32'(inflight), 32'h1);

        // fill to full: idx 0x011/0x012/0x015, ghr 0x002 -> 0x005 -> 0x00B
        drive(1, 32'h40, 0, 0, 0);
        drive(1, 32'h40, 1, 0, 0);
        drive(1, 32'h40, 1, 0, 0);
        check("inflight_full", 32'(inflight), 32'h4);
        check("f_ready_full", 32'(f_ready), 32'h0);
        check("ghr_full", 32'(ghr), 32'h00B);
        drive(1, 32'h40, 1, 0, 0);
        check("ghr_fifth", 32'(ghr), 32'h00B);
        check("inflight_fifth", 32'(inflight), 32'h4);

        // pop while full with fetch pending: fetch stays blocked that cycle
        expect_upd(12'h010, 1, 0);
        drive(1, 32'h40, 0, 1, 1);
        check("inflight_pop_full", 32'(inflight), 32'h3);
        check("ghr_pop_full", 32'(ghr), 32'h00B);
        expect_upd(12'h011, 0, 0);
        drive(0, 32'h0, 0, 1, 0);
        expect_upd(12'h012, 1, 0);
        drive(0, 32'h0, 0, 1, 1);
        expect_upd(12'h015, 1, 0);
        drive(0, 32'h0, 0, 1, 1);
        check("inflight_drained", 32'(inflight), 32'h0);
        check("ghr_drained", 32'(ghr), 32'h00B);

        // after wrap: idx 0x010^0x00B, mispredict repairs to {0x00B<<1,1}
        drive(1, 32'h40, 0, 0, 0);
        check("ghr_wrap_push", 32'(ghr), 32'h016);
        expect_upd(12'h01B, 1, 1);
        drive(0, 32'h0, 0, 1, 1);
        check("ghr_wrap_repair", 32'(ghr), 32'h017);
        check("inflight_wrap_repair", 32'(inflight), 32'h0);

        // correct prediction from clean reset
        do_reset();
        check_reset_state("rst1");
        drive(1, 32'h40, 1, 0, 0);
        expect_upd(12'h010, 1, 0);
        drive(0, 32'h0, 0, 1, 1);
        check("inflight_correct", 32'(inflight), 32'h0);
        check("ghr_correct", 32'(ghr), 32'h001);

        // mispredict with a same-cycle push that must be discarded
        do_reset();
        drive(1, 32'h40, 1, 0, 0);
        drive(1, 32'h40, 1, 0, 0);
        check("ghr_two_taken", 32'(ghr), 32'h003);
        expect_upd(12'h010, 0, 1);
        drive(1, 32'h80, 1, 1, 0);
        check("ghr_repair", 32'(ghr), 32'h000);
        check("inflight_flush", 32'(inflight), 32'h0);
        check("f_ready_flush", 32'(f_ready), 32'h1);

        // simultaneous push and correct pop at occupancy 2
        drive(1, 32'h100, 0, 0, 0);
        drive(1, 32'h104, 1, 0, 0);
        check("inflight_two", 32'(inflight), 32'h2);
        check("ghr_two", 32'(ghr), 32'h001);
        expect_upd(12'h040, 0, 0);
        drive(1, 32'h108, 0, 1, 0);
        check("inflight_pushpop", 32'(inflight), 32'h2);
        check("ghr_pushpop", 32'(ghr), 32'h002);
        expect_upd(12'h041, 1, 0);
        drive(0, 32'h0, 0, 1, 1);
        expect_upd(12'h043, 0, 0);
        drive(0, 32'h0, 0, 1, 0);
        check("inflight_empty", 32'(inflight), 32'h0);

        // resolve with nothing in flight
        drive(0, 32'h0, 0, 1, 1);
        #4;
        check("upd_valid_empty", 32'(upd_valid), 32'h0);
        check("mispredict_empty", 32'(mispredict), 32'h0);
        check("ghr_empty_resolve", 32'(ghr), 32'h002);

        // reset mid-operation with a resolve pending
        drive(1, 32'h40, 1, 0, 0);
        drive(1, 32'h40, 1, 0, 0);
        drive(1, 32'h40, 1, 0, 0);
        check("inflight_three", 32'(inflight), 32'h3);
        rst = 1'b1; e_valid = 1'b1; e_taken = 1'b1; f_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; e_valid = 1'b0; f_valid = 1'b0;
        check_reset_state("rst_mid");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
